// File: rtl/mem_io_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder_pkg
// Description : Address map constants and decode helpers for the memory/IO
//               responder on the CPU byte bus.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_io_responder_pkg;

    localparam logic [1:0] IO_PAGE     = 2'b11;
    localparam logic [2:0] IO_UART_OFF = 3'h0;
    localparam logic [2:0] IO_CLK_OFF  = 3'h4;

    typedef enum logic [1:0] {
        RGN_RAM_LO   = 2'b00,
        RGN_RAM_HI   = 2'b01,
        RGN_UNMAPPED = 2'b10,
        RGN_IO       = IO_PAGE
    } region_e;

    typedef struct packed {
        logic is_ram;
        logic is_io;
    } decode_t;

    function automatic decode_t decode_region(input logic [1:0] sel);
        decode_t d;
        d.is_ram = 1'b0;
        d.is_io  = 1'b0;
        case (region_e'(sel))
            RGN_RAM_LO, RGN_RAM_HI: d.is_ram = 1'b1;
            RGN_IO:                 d.is_io  = 1'b1;
            default:                ;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_io_responder_io_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder_io_tx_fifo
// Description : Byte-wide UART transmit FIFO with sticky overflow flag and a
//               look-ahead occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_responder_io_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count_next,
    output logic                     overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    r_mem [0:DEPTH-1];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_count == CW'(DEPTH));
    assign valid     = (r_count != '0);
    assign w_pop_ok  = pop & valid;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign w_push_ok = push & (~w_full | w_pop_ok);
    assign head      = r_mem[r_rd_ptr];
    assign overflow  = r_overflow;

    always_comb begin
        count_next = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   count_next = r_count + CW'(1);
            2'b01:   count_next = r_count - CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= count_next;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder
// Description : Byte-bus responder holding main RAM, the I/O page (UART RX/TX,
//               cycle counter snapshot, stop flag) and the TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_AW      = 17,
    parameter int TXF_DEPTH   = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] bus_a,
    input  logic        bus_wr,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic        io_buffer_full,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ack,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        program_done,
    output logic        tx_overflow
);
    localparam int CW = $clog2(TXF_DEPTH) + 1;

    decode_t           w_dec;
    logic [2:0]        w_io_off;
    logic [RAM_AW-1:0] w_ram_addr;
    logic              w_ram_wr;
    logic              w_unused_bits;

    logic [7:0]        w_io_rd_next;
    logic              w_rx_take;
    logic              w_snap_load;
    logic              w_tx_push;
    logic [7:0]        w_tx_push_data;
    logic              w_stop;
    logic [CW-1:0]     w_count_next;

    logic [7:0]        r_ram [0:(1 << RAM_AW)-1];
    logic [7:0]        r_ram_rd;
    logic              r_sel_ram;
    logic [7:0]        r_io_rd;
    logic              r_rx_ack;
    logic [31:0]       r_counter;
    logic [31:0]       r_snapshot;
    logic              r_done;
    logic              r_buf_full;

    assign w_dec         = decode_region(bus_a[17:16]);
    assign w_io_off      = bus_a[2:0];
    assign w_ram_addr    = bus_a[RAM_AW-1:0];
    assign w_ram_wr      = w_dec.is_ram & bus_wr;
    assign w_unused_bits = ^bus_a[31:18];

    // RAM array has no reset; its read register feeds the output mux directly.
    always_ff @(posedge clk_in) begin
        if (w_ram_wr) begin
            r_ram[w_ram_addr] <= bus_wdata;
        end
        r_ram_rd <= r_ram[w_ram_addr];
    end

    always_comb begin
        w_io_rd_next   = 8'h00;
        w_rx_take      = 1'b0;
        w_snap_load    = 1'b0;
        w_tx_push      = 1'b0;
        w_tx_push_data = 8'h00;
        w_stop         = 1'b0;
        if (w_dec.is_io) begin
            if (bus_wr) begin
                if (w_io_off == IO_UART_OFF && bus_wdata != 8'h00) begin
                    w_tx_push      = 1'b1;
                    w_tx_push_data = bus_wdata;
                end else if (w_io_off == IO_CLK_OFF) begin
                    // Stop write also emits a NUL so the host sees end-of-output.
                    w_tx_push = 1'b1;
                    w_stop    = 1'b1;
                end
            end else begin
                case (w_io_off)
                    IO_UART_OFF: begin
                        if (rx_valid) begin
                            w_io_rd_next = rx_data;
                            w_rx_take    = 1'b1;
                        end
                    end
                    IO_CLK_OFF: begin
                        w_io_rd_next = r_counter[7:0];
                        w_snap_load  = 1'b1;
                    end
                    3'h5:    w_io_rd_next = r_snapshot[15:8];
                    3'h6:    w_io_rd_next = r_snapshot[23:16];
                    3'h7:    w_io_rd_next = r_snapshot[31:24];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_sel_ram  <= 1'b0;
            r_io_rd    <= 8'h00;
            r_rx_ack   <= 1'b0;
            r_counter  <= 32'h0;
            r_snapshot <= 32'h0;
            r_done     <= 1'b0;
            r_buf_full <= 1'b0;
        end else begin
            r_counter  <= r_counter + 32'd1;
            r_sel_ram  <= w_dec.is_ram & ~bus_wr;
            r_io_rd    <= w_io_rd_next;
            r_rx_ack   <= w_rx_take;
            r_buf_full <= (CW'(TXF_DEPTH) - w_count_next) <= CW'(FULL_MARGIN);
            if (w_snap_load) begin
                r_snapshot <= r_counter;
            end
            if (w_stop) begin
                r_done <= 1'b1;
            end
        end
    end

    mem_io_responder_io_tx_fifo #(
        .DEPTH (TXF_DEPTH)
    ) u_tx_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .push       (w_tx_push),
        .push_data  (w_tx_push_data),
        .pop        (tx_ready),
        .head       (tx_data),
        .valid      (tx_valid),
        .count_next (w_count_next),
        .overflow   (tx_overflow)
    );

    assign bus_rdata      = r_sel_ram ? r_ram_rd : r_io_rd;
    assign rx_ack         = r_rx_ack;
    assign program_done   = r_done;
    assign io_buffer_full = r_buf_full;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_io_responder
// Description : Directed and random bus traffic checked against a queue/array
//               reference model of the memory map, TX FIFO and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_responder;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] bus_a = '0;
    logic        bus_wr = 1'b0;
    logic [7:0]  bus_wdata = '0;
    logic [7:0]  bus_rdata;
    logic        io_buffer_full;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ack;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        program_done;
    logic        tx_overflow;

    mem_io_responder #(
        .RAM_AW      (17),
        .TXF_DEPTH   (DEPTH),
        .FULL_MARGIN (MARGIN)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .bus_a          (bus_a),
        .bus_wr         (bus_wr),
        .bus_wdata      (bus_wdata),
        .bus_rdata      (bus_rdata),
        .io_buffer_full (io_buffer_full),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ack         (rx_ack),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .program_done   (program_done),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  m_ram [int];
    logic [7:0]  m_txq [$];
    logic [31:0] m_cyc;
    logic [31:0] m_snap;
    logic        m_done;
    logic        m_ovf;
    logic        m_rd_known;
    logic [7:0]  m_rd;
    logic        m_ack;
    logic [7:0]  dut_sent [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_txq.delete();
        m_cyc = 32'h0;
        m_snap = 32'h0;
        m_done = 1'b0;
        m_ovf = 1'b0;
        m_rd_known = 1'b1;
        m_rd = 8'h00;
        m_ack = 1'b0;
    endtask

    task automatic check_outputs();
        if (m_rd_known) chk("rdata", bus_rdata, m_rd);
        chk("rx_ack", rx_ack, m_ack);
        chk("tx_valid", tx_valid, m_txq.size() != 0);
        if (m_txq.size() != 0) chk("tx_data", tx_data, m_txq[0]);
        chk("buf_full", io_buffer_full, (DEPTH - m_txq.size()) <= MARGIN);
        chk("done", program_done, m_done);
        chk("overflow", tx_overflow, m_ovf);
    endtask

    // One bus transaction: drive at negedge, predict, clock, check at next negedge.
    task automatic cycle(input logic [31:0] a, input logic wr, input logic [7:0] wd,
                         input logic rxv, input logic [7:0] rxd, input logic txr);
        logic [1:0] rgn;
        logic [2:0] off;
        logic       pop;
        logic       push;
        logic [7:0] pv;
        if (tx_valid && txr) dut_sent.push_back(tx_data);
        bus_a = a; bus_wr = wr; bus_wdata = wd;
        rx_valid = rxv; rx_data = rxd; tx_ready = txr;
        rgn = a[17:16];
        off = a[2:0];
        pop = (m_txq.size() != 0) && txr;
        push = 1'b0;
        pv = 8'h00;
        m_rd_known = 1'b1;
        m_rd = 8'h00;
        m_ack = 1'b0;
        if (wr) begin
            m_rd_known = 1'b0;
            if (rgn < 2'd2) m_ram[int'(a[16:0])] = wd;
            else if (rgn == 2'd3) begin
                if (off == 3'd0 && wd != 8'h00) begin push = 1'b1; pv = wd; end
                else if (off == 3'd4) begin push = 1'b1; m_done = 1'b1; end
            end
        end else begin
            if (rgn < 2'd2) begin
                if (m_ram.exists(int'(a[16:0]))) m_rd = m_ram[int'(a[16:0])];
                else m_rd_known = 1'b0;
            end else if (rgn == 2'd3) begin
                if (off == 3'd0 && rxv) begin m_rd = rxd; m_ack = 1'b1; end
                else if (off == 3'd4) begin m_snap = m_cyc; m_rd = m_cyc[7:0]; end
                else if (off >= 3'd5) m_rd = 8'((m_snap >> (8 * (int'(off) - 4))) & 32'hFF);
            end
        end
        if (pop) void'(m_txq.pop_front());
        if (push) begin
            if (m_txq.size() < DEPTH) m_txq.push_back(pv);
            else m_ovf = 1'b1;
        end
        @(posedge clk_in);
        m_cyc = m_cyc + 32'd1;
        @(negedge clk_in);
        check_outputs();
    endtask

    task automatic idle(input logic txr);
        cycle(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, txr);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && tx_valid; i++) idle(1'b1);
        chk("drain_empty", tx_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        int k;
        model_reset();
        repeat (3) @(negedge clk_in);
        chk("rst_rdata", bus_rdata, 8'h00);
        chk("rst_txv", tx_valid, 1'b0);
        chk("rst_full", io_buffer_full, 1'b0);
        chk("rst_done", program_done, 1'b0);
        rst_in = 1'b1;

        // RAM pool used by every later test
        for (int i = 0; i < 32; i++) begin
            cycle(32'h0000_0000 + i, 1'b1, (i == 'h11) ? 8'h00 : 8'(i * 7 + 3), 1'b0, 8'h00, 1'b1);
            cycle(32'h0001_FFE0 + i, 1'b1, 8'(i ^ 'h5A), 1'b0, 8'h00, 1'b1);
        end

        // Test 1: RAM write then read back
        cycle(32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
        cycle(32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("t1_rd10", bus_rdata, 8'hA5);
        cycle(32'h0000_0011, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("t1_rd11", bus_rdata, 8'h00);

        // Test 2: zero byte filtered from TX stream
        dut_sent.delete();
        cycle(32'h0003_0000, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
        cycle(32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
        cycle(32'h0003_0000, 1'b1, 8'h42, 1'b0, 8'h00, 1'b1);
        repeat (3) idle(1'b1);
        chk("t2_count", dut_sent.size(), 2);
        if (dut_sent.size() == 2) begin
            chk("t2_b0", dut_sent[0], 8'h41);
            chk("t2_b1", dut_sent[1], 8'h42);
        end
        chk("t2_done", program_done, 1'b0);

        // Test 4: counter snapshot at 0x1FF
        for (int i = 0; i < 600 && m_cyc != 32'h1FF; i++) idle(1'b1);
        chk("t4_align", m_cyc, 32'h1FF);
        cycle(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("t4_b0", bus_rdata, 8'hFF);
        cycle(32'h0003_0005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("t4_b1", bus_rdata, 8'h01);
        cycle(32'h0003_0006, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("t4_b2", bus_rdata, 8'h00);
        cycle(32'h0003_0007, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("t4_b3", bus_rdata, 8'h00);
        cycle(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("t4_run", bus_rdata, 8'h03);

        // Test 5: RX read with and without data
        cycle(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h37, 1'b1);
        chk("t5_data", bus_rdata, 8'h37);
        chk("t5_ack", rx_ack, 1'b1);
        idle(1'b1);
        chk("t5_ack_once", rx_ack, 1'b0);
        cycle(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h99, 1'b1);
        chk("t5_nodata", bus_rdata, 8'h00);
        chk("t5_noack", rx_ack, 1'b0);

        // Test 3: fill, overflow, drain in order
        drain();
        for (int i = 0; i < 9; i++) begin
            cycle(32'h0003_0000, 1'b1, 8'(i + 1), 1'b0, 8'h00, 1'b0);
            if (i == 4) chk("t3_full5", io_buffer_full, 1'b0);
            if (i == 5) chk("t3_full6", io_buffer_full, 1'b1);
        end
        chk("t3_ovf", tx_overflow, 1'b1);
        dut_sent.delete();
        drain();
        chk("t3_count", dut_sent.size(), 8);
        for (int i = 0; i < 8 && i < dut_sent.size(); i++) chk("t3_order", dut_sent[i], 32'(i + 1));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            if (k < 4) a = (k[0] ? 32'h0001_FFE0 : 32'h0) + $urandom_range(0, 31);
            else if (k == 4) a = 32'h0002_0000 | ($urandom & 32'hFFFF);
            else a = 32'h0003_0000 | $urandom_range(0, 7) | (($urandom & 32'h1FFF) << 3);
            a = a | ($urandom << 18);
            cycle(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                  1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
        end
        drain();

        // Test 6: stop write, then async reset mid-drain
        cycle(32'h0003_0000, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
        cycle(32'h0003_0000, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
        cycle(32'h0003_0004, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("t6_done", program_done, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("t6_nul_valid", tx_valid, 1'b1);
        chk("t6_nul_data", tx_data, 8'h00);
        tx_ready = 1'b0;
        #2 rst_in = 1'b0;
        #1;
        chk("t6_rst_done", program_done, 1'b0);
        chk("t6_rst_txv", tx_valid, 1'b0);
        chk("t6_rst_ovf", tx_overflow, 1'b0);
        chk("t6_rst_full", io_buffer_full, 1'b0);
        chk("t6_rst_rdata", bus_rdata, 8'h00);
        chk("t6_rst_ack", rx_ack, 1'b0);
        @(negedge clk_in);
        rst_in = 1'b1;
        model_reset();
        cycle(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("t6_cnt0", bus_rdata, 8'h00);
        cycle(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("t6_cnt1", bus_rdata, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
Responder end of the CPU byte-wide memory bus (address / write-data / write-enable in, read-data out). It holds the 128 KB main RAM and the memory-mapped I/O page at 0x30000. It serves single-byte reads with one-cycle latency and absorbs writes in one cycle. It buffers UART output in a TX FIFO, drives io_buffer_full back to the CPU, supplies the cycle counter and flags program stop.

Parameters:
RAM_AW, 17, RAM byte-address width (RAM size 2^RAM_AW bytes)
TXF_DEPTH, 8, TX FIFO depth in bytes (power of 2, >=4)
FULL_MARGIN, 2, io_buffer_full asserts when free slots <= FULL_MARGIN

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous, active-low reset
bus_a  in  32  byte address from CPU (only [17:0] decoded)
bus_wr  in  1  1 = write, 0 = read
bus_wdata  in  8  write data from CPU
bus_rdata  out  8  read data, valid the cycle after the read address
io_buffer_full  out  1  TX FIFO nearly full; CPU must not issue UART writes
rx_valid  in  1  input byte available
rx_data  in  8  input byte
rx_ack  out  1  one-cycle pulse: rx_data consumed
tx_valid  out  1  TX FIFO head valid
tx_data  out  8  TX FIFO head byte
tx_ready  in  1  UART accepts head when tx_valid & tx_ready
program_done  out  1  sticky; set by stop write
tx_overflow  out  1  sticky; a TX push was dropped

Behaviour:
- Reset (rst_in low, async): bus_rdata=0, rx_ack=0, tx_valid=0, program_done=0, tx_overflow=0, FIFO empty, cycle counter=0, snapshot=0, io_buffer_full=0. RAM contents are not reset.
- Decode on bus_a[17:16]:
  - 2'b00 / 2'b01: RAM at bus_a[RAM_AW-1:0].
  - 2'b10: unmapped. Reads return 0x00; writes are ignored.
  - 2'b11: I/O page.
- Every cycle is a transaction; there is no idle encoding. A read of RAM 0x0 is harmless.
- RAM read: bus_rdata <= ram[a] at the clock edge, so data is visible in cycle N+1 for an address in cycle N. RAM write: ram[a] <= bus_wdata at the edge. A read of the same address in the next cycle returns the new value.
- I/O reads by bus_a[2:0]:
  - 0x0: if rx_valid, bus_rdata <= rx_data and rx_ack pulses in cycle N+1; otherwise bus_rdata <= 0x00 and no ack.
  - 0x4: snapshot <= counter, bus_rdata <= counter[7:0].
  - 0x5/0x6/0x7: bus_rdata <= snapshot byte 1/2/3.
  - Other offsets read 0x00.
- I/O writes:
  - 0x0 with nonzero data: push bus_wdata to the TX FIFO. A zero byte is ignored.
  - 0x4: push 0x00 to the TX FIFO and set program_done.
  - Other offsets are ignored.
- Counter: 32-bit, increments every cycle after reset, wraps at 2^32.
- TX FIFO:
  - tx_valid = count != 0; tx_data = head.
  - Pop and push in the same cycle on a non-empty FIFO: count is unchanged and ordering is preserved.
  - Push when full without a simultaneous pop: the byte is dropped and tx_overflow sets.
  - Pointers wrap modulo TXF_DEPTH.
  - io_buffer_full is registered: 1 when (TXF_DEPTH - count_next) <= FULL_MARGIN. It therefore leads actual fullness, covering a write already in flight.
- rx_ack is high only in the cycle after a qualifying read and never two cycles in a row for a single read.

Decomposition:
- Shared constants go in const.v: IO_PAGE (2'b11), IO_UART_OFF (3'h0), IO_CLK_OFF (3'h4).
- One sub-module: io_tx_fifo (parameterised depth, push/pop/full/count). The RAM array and decode stay in the top.

Test Plan:
1. Write 0xA5 to 0x00010, then read 0x00010 next cycle -> bus_rdata=0xA5 the cycle after the read; a read of 0x00011 (never written, preloaded 0x00) -> 0x00.
2. Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data sequence 0x41, 0x42 only; program_done stays 0.
3. Hold tx_ready=0 with TXF_DEPTH=8:
   - 6 nonzero writes -> io_buffer_full=1 after the 6th.
   - 3 more writes -> 8 accepted, 1 dropped, tx_overflow=1.
   - Release tx_ready -> exactly 8 bytes out, in order.
4. Read 0x30004..0x30007 on consecutive cycles starting at counter=0x0000_01FF -> bytes 0xFF, 0x01, 0x00, 0x00, all from the snapshot; the counter keeps running.
5. rx_valid=1, rx_data=0x37; read 0x30000 -> bus_rdata=0x37 and rx_ack=1 for one cycle. With rx_valid=0 -> bus_rdata=0x00, rx_ack=0.
6. Write to 0x30004, then drop rst_in low mid-drain:
   - Before reset: program_done=1 and 0x00 emitted on TX.
   - Reset asserted: all outputs clear immediately, asynchronously.
   - After reset: the counter restarts from 0.
